position_smoother: RTL and testbench
====================================

POSITION_SMOOTHER -- requirements
Module: position_smoother

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 11, width of coordinate inputs/outputs.
REQ-002 SHALL have parameter FRAME_X_MAX, default 640, x value marking end of frame.
REQ-003 SHALL have parameter FRAME_Y_MAX, default 480, y value marking end of frame.
REQ-004 SHALL have parameter ALPHA_SHIFT, default 2, IIR smoothing shift (0 = pass-through).
REQ-005 SHALL have parameter ACQ_FRAMES, default 3, range 2..15, consecutive valid frames required to declare track.
REQ-006 SHALL have parameter MISS_LIMIT, default 4, range 1..15, consecutive misses tolerated before track loss.
REQ-007 SHALL have port clk  input  1  single clock for all logic.
REQ-008 SHALL have port aresetn  input  1  asynchronous active-low reset.
REQ-009 SHALL have port enable  input  1  synchronous enable; low clears the block.
REQ-010 SHALL have port vga_x  input  INPUT_WIDTH  current scan x.
REQ-011 SHALL have port vga_y  input  INPUT_WIDTH  current scan y.
REQ-012 SHALL have port x_position  input  INPUT_WIDTH  raw centroid x from measure stage; all-ones = no object.
REQ-013 SHALL have port y_position  input  INPUT_WIDTH  raw centroid y; all-ones = no object.
REQ-014 SHALL have port x_smooth  output  INPUT_WIDTH  filtered x; all-ones when not tracking.
REQ-015 SHALL have port y_smooth  output  INPUT_WIDTH  filtered y; all-ones when not tracking.
REQ-016 SHALL have port track_valid  output  1  high in TRACK or COAST.
REQ-017 SHALL have port pos_update  output  1  one-cycle pulse when outputs take a new sample result.

Function
REQ-018 SHALL form frame_end = (vga_x==FRAME_X_MAX & vga_y==FRAME_Y_MAX) and detect its rising edge only; frame_end held N cycles yields exactly one sample.
REQ-019 SHALL sample x_position/y_position one clk after the frame_end rising edge (measure stage output registered on that edge).
REQ-020 SHALL treat a sample as a miss if either coordinate is all-ones, else a hit.
REQ-021 SHALL implement states LOST, ACQUIRE, TRACK, COAST; transitions evaluated only on sample cycles.
REQ-022 LOST: hit -> ACQUIRE, filter loaded directly with sample, hit_cnt=1; miss -> stay.
REQ-023 ACQUIRE: hit -> filter update, hit_cnt+1, move to TRACK when hit_cnt reaches ACQ_FRAMES; miss -> LOST, hit_cnt=0.
REQ-024 TRACK: hit -> filter update; miss -> COAST, miss_cnt=1, filter held.
REQ-025 COAST: hit -> TRACK, miss_cnt=0, filter update; miss -> miss_cnt+1, LOST when count exceeds MISS_LIMIT-1 (i.e. MISS_LIMIT consecutive misses from TRACK total).
REQ-026 Filter update SHALL be f = f + (s - f) >>> ALPHA_SHIFT, diff signed INPUT_WIDTH+1 bits, arithmetic shift (floor toward negative); result truncated to INPUT_WIDTH, always between f and s.
REQ-027 x and y filters SHALL update independently with identical arithmetic.
REQ-028 x_smooth/y_smooth SHALL equal filter registers in TRACK/COAST, all-ones in LOST/ACQUIRE; outputs registered.
REQ-029 pos_update SHALL pulse in the cycle outputs reflect the sample's result (two clk after frame_end rise), on every sample cycle.
REQ-030 enable low SHALL on the next edge force LOST, counters 0, filters 0, outputs all-ones, track_valid=0, pos_update=0, edge detector cleared; a pending sample is discarded.

Reset
REQ-031 aresetn low SHALL asynchronously force LOST, all counters/filters 0, x_smooth=y_smooth=all-ones, track_valid=0, pos_update=0, edge-detect history 0.
REQ-032 Reset deassertion mid-frame-end SHALL not generate a sample until a fresh frame_end rising edge.

Verification
REQ-033 Reset, 3 frames of hit (320,240) -> after 3rd pos_update track_valid=1, x_smooth=320, y_smooth=240; earlier outputs 2047.
REQ-034 In TRACK at x=320, hits x=400 x3 -> x_smooth 340, 355, 366.
REQ-035 In TRACK at 320: hit 319 -> 319; from 320 hit 316 -> 319 (floor rounding).
REQ-036 In TRACK, 3 misses -> COAST, x_smooth held 320, track_valid=1; 4th miss -> LOST, outputs 2047, track_valid=0.
REQ-037 LOST, 2 hits then miss -> LOST, track_valid never asserted; frame_end held 5 cycles -> exactly one pos_update.
REQ-038 TRACK, enable low one cycle -> next cycle outputs 2047, track_valid=0; reacquisition needs 3 new hits.

Source files
------------

// File: rtl/position_smoother.sv
// Position smoother: samples the per-frame centroid from the measure stage,
// runs a LOST/ACQUIRE/TRACK/COAST track-confidence state machine and an IIR
// filter per axis, and presents registered smoothed coordinates.
module position_smoother #(
  parameter int INPUT_WIDTH = 11,
  parameter int FRAME_X_MAX = 640,
  parameter int FRAME_Y_MAX = 480,
  parameter int ALPHA_SHIFT = 2,
  parameter int ACQ_FRAMES  = 3,
  parameter int MISS_LIMIT  = 4
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   enable,
  input  logic [INPUT_WIDTH-1:0] vga_x,
  input  logic [INPUT_WIDTH-1:0] vga_y,
  input  logic [INPUT_WIDTH-1:0] x_position,
  input  logic [INPUT_WIDTH-1:0] y_position,
  output logic [INPUT_WIDTH-1:0] x_smooth,
  output logic [INPUT_WIDTH-1:0] y_smooth,
  output logic                   track_valid,
  output logic                   pos_update
);

  localparam int W = INPUT_WIDTH;
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
  localparam logic [W-1:0] X_END    = W'(FRAME_X_MAX);
  localparam logic [W-1:0] Y_END    = W'(FRAME_Y_MAX);
  localparam logic [3:0]   ACQ_N    = 4'(ACQ_FRAMES);
  localparam logic [3:0]   MISS_N   = 4'(MISS_LIMIT);

  typedef enum logic [1:0] {
    ST_LOST,
    ST_ACQUIRE,
    ST_TRACK,
    ST_COAST
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   hit_cnt_q, hit_cnt_d;
  logic [3:0]   miss_cnt_q, miss_cnt_d;
  logic [W-1:0] filt_x_q, filt_x_d;
  logic [W-1:0] filt_y_q, filt_y_d;
  logic [W-1:0] x_smooth_q, x_smooth_d;
  logic [W-1:0] y_smooth_q, y_smooth_d;
  logic         track_valid_q, track_valid_d;
  logic         pos_update_q, pos_update_d;
  logic         frame_end_q, frame_end_d;
  logic         armed_q, armed_d;
  logic         sample_q, sample_d;

  logic         frame_end;
  logic         frame_rise;
  logic         hit;

  // One IIR step: f + floor((s - f) / 2^ALPHA_SHIFT). The difference is kept
  // one bit wider and shifted arithmetically so the step always lands
  // between f and s and the truncated sum cannot wrap.
  function automatic logic [W-1:0] filt_step(input logic [W-1:0] f,
                                             input logic [W-1:0] s);
    logic signed [W:0] diff;
    logic signed [W:0] step;
    logic        [W:0] sum;
    diff = signed'({1'b0, s}) - signed'({1'b0, f});
    step = diff >>> ALPHA_SHIFT;
    sum  = {1'b0, f} + unsigned'(step);
    return sum[W-1:0];
  endfunction

  assign frame_end  = (vga_x == X_END) && (vga_y == Y_END);
  // armed_q stays low until frame_end has been seen low, so a frame_end that
  // is already high when reset or enable releases never counts as a rise.
  assign frame_rise = frame_end && !frame_end_q && armed_q;
  assign hit        = (x_position != ALL_ONES) && (y_position != ALL_ONES);

  // Next-state, counter, filter and output computation.
  always_comb begin
    // NOTE: every _d gets a default before any branch so no path leaves a
    // variable unassigned, which would infer a latch.
    state_d       = state_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    filt_x_d      = filt_x_q;
    filt_y_d      = filt_y_q;
    frame_end_d   = frame_end;
    armed_d       = armed_q | ~frame_end;
    sample_d      = frame_rise;
    pos_update_d  = 1'b0;

    if (sample_q) begin
      pos_update_d = 1'b1;
      unique case (state_q)
        ST_LOST: begin
          if (hit) begin
            state_d   = ST_ACQUIRE;
            filt_x_d  = x_position;
            filt_y_d  = y_position;
            hit_cnt_d = 4'd1;
          end
        end
        ST_ACQUIRE: begin
          if (hit) begin
            filt_x_d  = filt_step(filt_x_q, x_position);
            filt_y_d  = filt_step(filt_y_q, y_position);
            hit_cnt_d = hit_cnt_q + 4'd1;
            if (hit_cnt_d >= ACQ_N) begin
              state_d = ST_TRACK;
            end
          end else begin
            state_d   = ST_LOST;
            hit_cnt_d = 4'd0;
          end
        end
        ST_TRACK: begin
          if (hit) begin
            filt_x_d = filt_step(filt_x_q, x_position);
            filt_y_d = filt_step(filt_y_q, y_position);
          end else if (MISS_N <= 4'd1) begin
            state_d    = ST_LOST;
            hit_cnt_d  = 4'd0;
            miss_cnt_d = 4'd0;
          end else begin
            state_d    = ST_COAST;
            miss_cnt_d = 4'd1;
          end
        end
        ST_COAST: begin
          if (hit) begin
            state_d    = ST_TRACK;
            miss_cnt_d = 4'd0;
            filt_x_d   = filt_step(filt_x_q, x_position);
            filt_y_d   = filt_step(filt_y_q, y_position);
          end else begin
            miss_cnt_d = miss_cnt_q + 4'd1;
            if (miss_cnt_d >= MISS_N) begin
              state_d    = ST_LOST;
              hit_cnt_d  = 4'd0;
              miss_cnt_d = 4'd0;
            end
          end
        end
        default: state_d = ST_LOST;
      endcase
    end

    if (!enable) begin
      state_d      = ST_LOST;
      hit_cnt_d    = 4'd0;
      miss_cnt_d   = 4'd0;
      filt_x_d     = '0;
      filt_y_d     = '0;
      frame_end_d  = 1'b0;
      armed_d      = 1'b0;
      sample_d     = 1'b0;
      pos_update_d = 1'b0;
    end

    // Outputs follow the post-sample state so they change with pos_update.
    track_valid_d = (state_d == ST_TRACK) || (state_d == ST_COAST);
    x_smooth_d    = track_valid_d ? filt_x_d : ALL_ONES;
    y_smooth_d    = track_valid_d ? filt_y_d : ALL_ONES;
  end

  // State, counter, filter, edge-detect and output registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_LOST;
      hit_cnt_q     <= 4'd0;
      miss_cnt_q    <= 4'd0;
      filt_x_q      <= '0;
      filt_y_q      <= '0;
      x_smooth_q    <= ALL_ONES;
      y_smooth_q    <= ALL_ONES;
      track_valid_q <= 1'b0;
      pos_update_q  <= 1'b0;
      frame_end_q   <= 1'b0;
      armed_q       <= 1'b0;
      sample_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q       <= state_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      filt_x_q      <= filt_x_d;
      filt_y_q      <= filt_y_d;
      x_smooth_q    <= x_smooth_d;
      y_smooth_q    <= y_smooth_d;
      track_valid_q <= track_valid_d;
      pos_update_q  <= pos_update_d;
      frame_end_q   <= frame_end_d;
      armed_q       <= armed_d;
      sample_q      <= sample_d;
    end
  end

  assign x_smooth    = x_smooth_q;
  assign y_smooth    = y_smooth_q;
  assign track_valid = track_valid_q;
  assign pos_update  = pos_update_q;

endmodule

// File: tb/tb_position_smoother.sv
// Self-checking bench for position_smoother: directed scenarios plus a
// randomized hit/miss sequence, all compared to a behavioural track model.
module tb_position_smoother;

  localparam int W     = 11;
  localparam int XMAX  = 640;
  localparam int YMAX  = 480;
  localparam int ALPHA = 2;
  localparam int ACQ   = 3;
  localparam int MISSL = 4;
  localparam int NONE  = 2047;

  logic         clk = 1'b0;
  logic         aresetn = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] vga_x = '0;
  logic [W-1:0] vga_y = '0;
  logic [W-1:0] x_position = '1;
  logic [W-1:0] y_position = '1;
  logic [W-1:0] x_smooth;
  logic [W-1:0] y_smooth;
  logic         track_valid;
  logic         pos_update;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a tracking flag with acquisition and miss counts.
  bit m_tracking;
  int m_acq;
  int m_miss;
  int m_fx;
  int m_fy;

  position_smoother #(
    .INPUT_WIDTH(W), .FRAME_X_MAX(XMAX), .FRAME_Y_MAX(YMAX),
    .ALPHA_SHIFT(ALPHA), .ACQ_FRAMES(ACQ), .MISS_LIMIT(MISSL)
  ) dut (
    .clk(clk), .aresetn(aresetn), .enable(enable),
    .vga_x(vga_x), .vga_y(vga_y),
    .x_position(x_position), .y_position(y_position),
    .x_smooth(x_smooth), .y_smooth(y_smooth),
    .track_valid(track_valid), .pos_update(pos_update)
  );

  always #5 clk = ~clk;

  function automatic int m_filt(int f, int s);
    int d;
    int div;
    int q;
    d   = s - f;
    div = 1 << ALPHA;
    if (d >= 0) q = d / div;
    else        q = -((-d + div - 1) / div);
    return f + q;
  endfunction

  task automatic model_clear();
    m_tracking = 0; m_acq = 0; m_miss = 0; m_fx = 0; m_fy = 0;
  endtask

  task automatic model_step(input int sx, input int sy);
    bit is_hit;
    is_hit = (sx != NONE) && (sy != NONE);
    if (!m_tracking) begin
      if (is_hit) begin
        if (m_acq == 0) begin m_fx = sx; m_fy = sy; end
        else begin m_fx = m_filt(m_fx, sx); m_fy = m_filt(m_fy, sy); end
        m_acq++;
        if (m_acq >= ACQ) begin m_tracking = 1; m_acq = 0; m_miss = 0; end
      end else begin
        m_acq = 0;
      end
    end else if (is_hit) begin
      m_miss = 0;
      m_fx = m_filt(m_fx, sx);
      m_fy = m_filt(m_fy, sy);
    end else begin
      m_miss++;
      if (m_miss >= MISSL) begin m_tracking = 0; m_acq = 0; m_miss = 0; end
    end
  endtask

  task automatic check_idle(input string tag);
    n_checks++;
    if (x_smooth !== 11'h7FF || y_smooth !== 11'h7FF || track_valid !== 1'b0 ||
        pos_update !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got x=%0d y=%0d tv=%b pu=%b, want x=2047 y=2047 tv=0 pu=0",
               tag, x_smooth, y_smooth, track_valid, pos_update);
    end
  endtask

  // Presents one frame-end window of `hold` cycles with sample (sx,sy),
  // expects exactly one pos_update two cycles after the rise, and compares
  // the outputs seen with that pulse to the model.
  task automatic run_frame(input int sx, input int sy, input int hold,
                           input string tag, output int ox);
    int pulses;
    int at;
    int oy;
    logic otv;
    int ex;
    int ey;
    pulses = 0; at = -1; ox = -1; oy = -1; otv = 1'bx;
    @(posedge clk); #1;
    x_position = W'(sx); y_position = W'(sy);
    vga_x = W'(XMAX); vga_y = W'(YMAX);
    for (int k = 0; k < hold + 5; k++) begin
      @(negedge clk);
      if (pos_update === 1'b1) begin
        pulses++; at = k; ox = int'(x_smooth); oy = int'(y_smooth); otv = track_valid;
      end
      @(posedge clk); #1;
      if (k == hold - 1) begin vga_x = '0; vga_y = '0; end
    end
    model_step(sx, sy);
    ex = m_tracking ? m_fx : NONE;
    ey = m_tracking ? m_fy : NONE;
    n_checks++;
    if (pulses != 1 || at != 2) begin
      n_fail++;
      $display("FAIL %s pulse: got %0d pulses at cycle %0d, want 1 at cycle 2",
               tag, pulses, at);
    end
    n_checks++;
    if (ox != ex || oy != ey || otv !== m_tracking) begin
      n_fail++;
      $display("FAIL %s outputs: got x=%0d y=%0d tv=%b, want x=%0d y=%0d tv=%b",
               tag, ox, oy, otv, ex, ey, m_tracking);
    end
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (pos_update === 1'b1) pulses++;
    end
  endtask

  task automatic disable_one_cycle();
    @(posedge clk); #1; enable = 1'b0;
    @(posedge clk); #1; enable = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    model_clear();
    aresetn = 1'b0; enable = 1'b1;
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;
    @(negedge clk);
    check_idle("reset_state");
  endtask

  task automatic test_acquire();
    int ox;
    run_frame(320, 240, 1, "acq1", ox);
    n_checks++;
    if (ox != NONE) begin n_fail++; $display("FAIL acq1_x: got %0d, want 2047", ox); end
    run_frame(320, 240, 1, "acq2", ox);
    run_frame(320, 240, 1, "acq3", ox);
    n_checks++;
    if (ox != 320 || track_valid !== 1'b1 || y_smooth !== 11'd240) begin
      n_fail++;
      $display("FAIL acq3_track: got x=%0d y=%0d tv=%b, want x=320 y=240 tv=1",
               ox, y_smooth, track_valid);
    end
  endtask

  task automatic test_step_response();
    int ox;
    int want[3] = '{340, 355, 366};
    for (int i = 0; i < 3; i++) begin
      run_frame(400, 240, 1, "step", ox);
      n_checks++;
      if (ox != want[i]) begin
        n_fail++;
        $display("FAIL step%0d: got x=%0d, want %0d", i, ox, want[i]);
      end
    end
  endtask

  task automatic reacquire_at(input int x, input int y);
    int ox;
    disable_one_cycle();
    for (int i = 0; i < ACQ; i++) run_frame(x, y, 1, "reacq", ox);
  endtask

  task automatic test_rounding();
    int ox;
    reacquire_at(320, 240);
    run_frame(319, 240, 1, "round_319", ox);
    n_checks++;
    if (ox != 319) begin n_fail++; $display("FAIL round_319: got %0d, want 319", ox); end
    reacquire_at(320, 240);
    run_frame(316, 240, 2, "round_316", ox);
    n_checks++;
    if (ox != 319) begin n_fail++; $display("FAIL round_316: got %0d, want 319", ox); end
  endtask

  task automatic test_coast_loss();
    int ox;
    reacquire_at(320, 240);
    for (int i = 0; i < 3; i++) begin
      run_frame(NONE, 100, 1, "coast", ox);
      n_checks++;
      if (ox != 320 || track_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL coast%0d: got x=%0d tv=%b, want x=320 tv=1", i, ox, track_valid);
      end
    end
    run_frame(100, NONE, 1, "lost", ox);
    n_checks++;
    if (ox != NONE || track_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lost: got x=%0d tv=%b, want x=2047 tv=0", ox, track_valid);
    end
  endtask

  task automatic test_false_acquire();
    int ox;
    bit seen_tv;
    seen_tv = 0;
    run_frame(50, 60, 5, "fa_hit1", ox);
    seen_tv |= track_valid;
    run_frame(50, 60, 3, "fa_hit2", ox);
    seen_tv |= track_valid;
    run_frame(NONE, NONE, 5, "fa_miss", ox);
    seen_tv |= track_valid;
    n_checks++;
    if (seen_tv) begin n_fail++; $display("FAIL false_acq: got tv=1, want tv never 1"); end
  endtask

  task automatic test_enable();
    int ox;
    int pulses;
    reacquire_at(320, 240);
    disable_one_cycle();
    @(negedge clk);
    check_idle("enable_clear");
    // Sample pending when enable drops must be discarded.
    reacquire_at(500, 400);
    @(posedge clk); #1; x_position = 11'd10; vga_x = W'(XMAX); vga_y = W'(YMAX);
    @(posedge clk); #1; enable = 1'b0; vga_x = '0; vga_y = '0;
    @(posedge clk); #1; enable = 1'b1;
    model_clear();
    count_pulses(5, pulses);
    n_checks++;
    if (pulses != 0 || track_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pending_discard: got %0d pulses tv=%b, want 0 pulses tv=0",
               pulses, track_valid);
    end
    run_frame(200, 150, 1, "en_reacq1", ox);
    run_frame(200, 150, 1, "en_reacq2", ox);
    run_frame(200, 150, 1, "en_reacq3", ox);
    n_checks++;
    if (ox != 200 || track_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL en_reacq: got x=%0d tv=%b, want x=200 tv=1", ox, track_valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    int pulses;
    // Enter reset while tracking and while frame_end is high.
    @(posedge clk); #1; vga_x = W'(XMAX); vga_y = W'(YMAX); x_position = 11'd7;
    #2 aresetn = 1'b0;
    #1;
    check_idle("async_reset");
    @(posedge clk); #1 aresetn = 1'b1;
    model_clear();
    count_pulses(6, pulses);
    @(posedge clk); #1; vga_x = '0; vga_y = '0;
    count_pulses(4, pulses);
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL reset_mid_frame: got %0d pulses, want 0", pulses);
    end
  endtask

  task automatic test_random();
    int ox;
    int sx;
    int sy;
    for (int i = 0; i < 60; i++) begin
      sx = $urandom_range(0, NONE - 1);
      sy = $urandom_range(0, NONE - 1);
      if ($urandom_range(0, 9) < 3) begin
        if ($urandom_range(0, 1) == 0) sx = NONE; else sy = NONE;
      end
      run_frame(sx, sy, $urandom_range(1, 4), "random", ox);
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_step_response();
    test_rounding();
    test_coast_loss();
    test_false_acquire();
    test_enable();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
